// File: rtl/expr_eval_if.sv
// Character-stream bus between the expression source and expr_eval.
// The master feeds one ASCII character per accepted cycle; the slave
// returns the running value and the status flags.
interface expr_eval_if #(
    parameter int W = 16
);
    logic         restart;
    logic [7:0]   in;
    logic         in_valid;
    logic [W-1:0] value;
    logic         ok;
    logic         err;
    logic         ovf;

    modport master (
        output restart,
        output in,
        output in_valid,
        input  value,
        input  ok,
        input  err,
        input  ovf
    );

    modport slave (
        input  restart,
        input  in,
        input  in_valid,
        output value,
        output ok,
        output err,
        output ovf
    );
endinterface

// File: rtl/expr_eval.sv
// expr_eval: evaluates NUM (OP NUM)* over a one-character-per-cycle ASCII
// stream, with '*' binding tighter than '+'. Arithmetic is unsigned
// modulo 2^W; any wrapped intermediate sets a sticky ovf flag.
//
// The running expression is kept as sum + prod*num:
//   sum  - total of all completed '+' terms
//   prod - product of the completed factors of the current term
//   num  - the number currently being typed
//
// state   | meaning
// --------+----------------------------------------------------------
// S_START | nothing consumed since reset/restart
// S_NUM   | last character was a digit; expression is complete (ok)
// S_OP    | last character was an operator; a number must follow
// S_ERR   | syntax error seen; absorbing until clr_n or restart
module expr_eval #(
    parameter int W = 16
) (
    input logic        clk,
    input logic        clr_n,
    expr_eval_if.slave bus
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_NUM   = 2'd1;
    localparam logic [1:0] S_OP    = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    logic [1:0]     state;
    logic [1:0]     state_nx;
    logic [W-1:0]   sum;
    logic [W-1:0]   sum_nx;
    logic [W-1:0]   prod;
    logic [W-1:0]   prod_nx;
    logic [W-1:0]   num;
    logic [W-1:0]   num_nx;
    logic [W-1:0]   value;
    logic [W-1:0]   value_nx;
    logic           ovf;
    logic           ovf_nx;

    logic           is_digit;
    logic           is_mul;
    logic           is_add;

    // Digit path: num*10+d, then the term prod*num' and the new value.
    logic [W+3:0]   num_ext;
    logic [W+3:0]   num_full;
    logic [W-1:0]   num_dig;
    logic [2*W-1:0] dig_term_full;
    logic [W:0]     dig_val_full;
    logic           dig_ovf;

    // Operator path: closes the current factor (prod*num) and, for '+',
    // folds the finished term into sum.
    logic [2*W-1:0] cur_term_full;
    logic [W:0]     add_sum_full;
    logic           mul_ovf;
    logic           add_ovf;

    assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    assign is_mul   = (bus.in == 8'h2A);
    assign is_add   = (bus.in == 8'h2B);

    // Full-precision intermediates; only the low W bits are kept, the rest
    // feed the overflow detection.
    assign num_ext       = {4'b0000, num};
    assign num_full      = (num_ext << 3) + (num_ext << 1) + {{W{1'b0}}, bus.in[3:0]};
    assign num_dig       = num_full[W-1:0];
    assign dig_term_full = {{W{1'b0}}, prod} * {{W{1'b0}}, num_dig};
    assign dig_val_full  = {1'b0, sum} + {1'b0, dig_term_full[W-1:0]};
    assign dig_ovf       = (|num_full[W+3:W]) | (|dig_term_full[2*W-1:W]) | dig_val_full[W];

    assign cur_term_full = {{W{1'b0}}, prod} * {{W{1'b0}}, num};
    assign add_sum_full  = {1'b0, sum} + {1'b0, cur_term_full[W-1:0]};
    assign mul_ovf       = |cur_term_full[2*W-1:W];
    assign add_ovf       = mul_ovf | add_sum_full[W];

    // Next-state and datapath update for one accepted character.
    always_comb begin
        state_nx = state;
        sum_nx   = sum;
        prod_nx  = prod;
        num_nx   = num;
        value_nx = value;
        ovf_nx   = ovf;
        if (bus.in_valid && (state != S_ERR)) begin
            if (is_digit) begin
                num_nx   = num_dig;
                value_nx = dig_val_full[W-1:0];
                ovf_nx   = ovf | dig_ovf;
                state_nx = S_NUM;
            end else if (is_mul && (state == S_NUM)) begin
                prod_nx  = cur_term_full[W-1:0];
                num_nx   = '0;
                ovf_nx   = ovf | mul_ovf;
                state_nx = S_OP;
            end else if (is_add && (state == S_NUM)) begin
                sum_nx   = add_sum_full[W-1:0];
                prod_nx  = ONE_W;
                num_nx   = '0;
                ovf_nx   = ovf | add_ovf;
                state_nx = S_OP;
            end else begin
                // Bad character or misplaced operator: accumulators keep
                // their contents, ovf is left as it was.
                value_nx = '0;
                state_nx = S_ERR;
            end
        end
    end

    // State registers: async clear, synchronous restart ahead of input.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_START;
            sum   <= '0;
            prod  <= ONE_W;
            num   <= '0;
            value <= '0;
            ovf   <= 1'b0;
        end else if (bus.restart) begin
            state <= S_START;
            sum   <= '0;
            prod  <= ONE_W;
            num   <= '0;
            value <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            sum   <= sum_nx;
            prod  <= prod_nx;
            num   <= num_nx;
            value <= value_nx;
            ovf   <= ovf_nx;
        end
    end

    assign bus.value = value;
    assign bus.ok    = (state == S_NUM);
    assign bus.err   = (state == S_ERR);
    assign bus.ovf   = ovf;

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a W=16 and a W=8 instance share clock and
// clr_n. Stimulus pushes the expected outputs into a queue; the monitor
// pops and compares one cycle later (or right after an async clear).
module tb_expr_eval;

    logic clk;
    logic clr_n;

    expr_eval_if #(.W(16)) if16 ();
    expr_eval_if #(.W(8))  if8 ();

    expr_eval #(.W(16)) dut16 (.clk(clk), .clr_n(clr_n), .bus(if16));
    expr_eval #(.W(8))  dut8  (.clk(clk), .clr_n(clr_n), .bus(if8));

    typedef struct {
        bit          sel8;
        logic [15:0] v;
        bit          ok;
        bit          err;
        bit          ovf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    event  chk_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every pending expectation just after the edge.
    initial begin
        exp_t        e;
        string       nm;
        logic [15:0] av;
        logic        aok, aerr, aovf;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.sel8) begin
                    av = {8'h00, if8.value}; aok = if8.ok; aerr = if8.err; aovf = if8.ovf;
                end else begin
                    av = if16.value; aok = if16.ok; aerr = if16.err; aovf = if16.ovf;
                end
                n_checks++;
                if (av !== e.v || aok !== e.ok || aerr !== e.err || aovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL %s: got value=%0d ok=%b err=%b ovf=%b, expected value=%0d ok=%b err=%b ovf=%b",
                             nm, av, aok, aerr, aovf, e.v, e.ok, e.err, e.ovf);
                end
            end
        end
    end

    task automatic push_exp(input bit sel8, input logic [15:0] ev, input bit eok,
                            input bit eerr, input bit eovf, input string nm);
        exp_t e;
        e.sel8 = sel8; e.v = ev; e.ok = eok; e.err = eerr; e.ovf = eovf;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One cycle of stimulus on the chosen instance; the other one idles.
    task automatic step(input bit sel8, input bit rs, input bit vld, input logic [7:0] ch,
                        input logic [15:0] ev, input bit eok, input bit eerr, input bit eovf,
                        input string nm);
        @(negedge clk);
        if16.restart  = !sel8 && rs;
        if16.in_valid = !sel8 && vld;
        if16.in       = ch;
        if8.restart   = sel8 && rs;
        if8.in_valid  = sel8 && vld;
        if8.in        = ch;
        push_exp(sel8, ev, eok, eerr, eovf, nm);
    endtask

    task automatic c16(input logic [7:0] ch, input logic [15:0] ev, input bit eok,
                       input bit eerr, input bit eovf, input string nm);
        step(1'b0, 1'b0, 1'b1, ch, ev, eok, eerr, eovf, nm);
    endtask

    task automatic c8(input logic [7:0] ch, input logic [15:0] ev, input bit eok,
                      input bit eerr, input bit eovf, input string nm);
        step(1'b1, 1'b0, 1'b1, ch, ev, eok, eerr, eovf, nm);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        clr_n = 1'b0;
        if16.restart = 1'b0; if16.in_valid = 1'b0; if16.in = 8'h00;
        if8.restart  = 1'b0; if8.in_valid  = 1'b0; if8.in  = 8'h00;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 0, 0, 0, "reset16");
        step(1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 0, 0, 0, "reset8");

        // "3+4*5"
        c16("3", 16'd3,  1, 0, 0, "t1_3");
        c16("+", 16'd3,  0, 0, 0, "t1_plus");
        c16("4", 16'd7,  1, 0, 0, "t1_4");
        c16("*", 16'd7,  0, 0, 0, "t1_mul");
        c16("5", 16'd23, 1, 0, 0, "t1_5");
        step(1'b0, 1'b0, 1'b0, 8'h00, 16'd23, 1, 0, 0, "t1_hold");

        // "12*3+7" with two idle cycles after '*'
        step(1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t2_restart");
        c16("1", 16'd1,  1, 0, 0, "t2_1");
        c16("2", 16'd12, 1, 0, 0, "t2_12");
        c16("*", 16'd12, 0, 0, 0, "t2_mul");
        step(1'b0, 1'b0, 1'b0, "9", 16'd12, 0, 0, 0, "t2_idle_a");
        step(1'b0, 1'b0, 1'b0, "9", 16'd12, 0, 0, 0, "t2_idle_b");
        c16("3", 16'd36, 1, 0, 0, "t2_3");
        c16("+", 16'd36, 0, 0, 0, "t2_plus");
        c16("7", 16'd43, 1, 0, 0, "t2_7");
        step(1'b0, 1'b0, 1'b0, 8'h00, 16'd43, 1, 0, 0, "t2_hold");

        // "+5": leading operator is an error, S_ERR absorbs the digit
        step(1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t3_restart");
        c16("+", 16'd0, 0, 1, 0, "t3_plus_err");
        c16("5", 16'd0, 0, 1, 0, "t3_err_absorb");
        step(1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t3_restart_clr");
        c16("5", 16'd5, 1, 0, 0, "t3_5");

        // "9*" then 'x', then restart with a valid character
        step(1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t4_restart");
        c16("9", 16'd9, 1, 0, 0, "t4_9");
        c16("*", 16'd9, 0, 0, 0, "t4_mul");
        c16("x", 16'd0, 0, 1, 0, "t4_x_err");
        step(1'b0, 1'b1, 1'b1, "7", 16'd0, 0, 0, 0, "t4_restart_wins");
        step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t4_dropped");
        c16("*", 16'd0, 0, 1, 0, "t4_op_in_start");

        // W=8: "255*2", "300", error keeps ovf, "1+1"
        c8("2", 16'd2,   1, 0, 0, "t5_2");
        c8("5", 16'd25,  1, 0, 0, "t5_25");
        c8("5", 16'd255, 1, 0, 0, "t5_255");
        c8("*", 16'd255, 0, 0, 0, "t5_mul");
        c8("2", 16'd254, 1, 0, 1, "t5_prod_wrap");
        step(1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t5_restart_a");
        c8("3", 16'd3,  1, 0, 0, "t5_3");
        c8("0", 16'd30, 1, 0, 0, "t5_30");
        c8("0", 16'd44, 1, 0, 1, "t5_num_wrap");
        c8("x", 16'd0,  0, 1, 1, "t5_err_keeps_ovf");
        step(1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t5_restart_b");
        c8("1", 16'd1, 1, 0, 0, "t5_1");
        c8("+", 16'd1, 0, 0, 0, "t5_plus");
        c8("1", 16'd2, 1, 0, 0, "t5_1p1");
        c8("0", 16'd11, 1, 0, 0, "t5_1p10");

        // "8*8" then async clear between edges
        step(1'b0, 1'b1, 1'b0, 8'h00, 16'd0, 0, 0, 0, "t6_restart");
        c16("8", 16'd8,  1, 0, 0, "t6_8");
        c16("*", 16'd8,  0, 0, 0, "t6_mul");
        c16("8", 16'd64, 1, 0, 0, "t6_64");
        step(1'b0, 1'b0, 1'b0, 8'h00, 16'd64, 1, 0, 0, "t6_hold");
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        push_exp(1'b0, 16'd0, 0, 0, 0, "t6_async_clr16");
        push_exp(1'b1, 16'd0, 0, 0, 0, "t6_async_clr8");
        -> chk_ev;
        @(negedge clk);
        clr_n = 1'b1;
        c16("2", 16'd2, 1, 0, 0, "t6_2");
        c16("+", 16'd2, 0, 0, 0, "t6_plus");
        c16("2", 16'd4, 1, 0, 0, "t6_2p2");
        step(1'b0, 1'b0, 1'b0, 8'h00, 16'd4, 1, 0, 0, "t6_hold_end");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream companion to the expression-recogniser stage: consumes the same one-character-per-cycle ASCII stream and computes the expression's numeric value.
- Grammar: NUM (OP NUM)*. NUM is one or more decimal digits ('0'-'9'). OP is '*' (0x2A) or '+' (0x2B).
- '*' binds tighter than '+'.
- Arithmetic is unsigned modulo 2^W, with a sticky overflow flag.
- Feeds the result/status display logic.

Parameters:
- W, 16, width of the result and of all internal accumulators (sum, prod, num).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- clr_n, input, 1, asynchronous active-low reset.
- restart, input, 1, synchronous clear to the reset state; has priority over in_valid.
- in, input, 8, ASCII character.
- in_valid, input, 1, in is consumed on a rising edge only when in_valid=1.
- value, output, W, value of the last complete expression prefix.
- ok, output, 1, 1 when the characters consumed so far form a complete valid expression.
- err, output, 1, sticky syntax error.
- ovf, output, 1, sticky arithmetic wrap.

Behaviour:
- Registers: state (S_START, S_NUM, S_OP, S_ERR), sum[W], prod[W], num[W], value[W], ovf.
- Reset (clr_n=0, async) and restart=1 (sync) both give: state=S_START, sum=0, prod=1, num=0, value=0, ovf=0.
- Outputs are Moore:
  - ok = (state==S_NUM).
  - err = (state==S_ERR).
  - value and ovf are registers.
- in_valid=0: every register holds.
- Digit d in S_START, S_OP or S_NUM:
  - num <= num*10+d.
  - state <= S_NUM.
  - value <= sum + prod*(num*10+d).
- '*' in S_NUM: prod <= prod*num; num <= 0; state <= S_OP.
- '+' in S_NUM: sum <= sum + prod*num; prod <= 1; num <= 0; state <= S_OP.
- Any other character, or any operator in S_START/S_OP:
  - state <= S_ERR.
  - value <= 0.
  - sum, prod, num hold.
- S_ERR is absorbing: ignores all input; leaves only via clr_n or restart.
- Width rule:
  - Compute each intermediate at full precision (products 2W bits, num*10+d W+4 bits), then truncate to W.
  - ovf <= 1 if any truncated bit of any intermediate used that cycle is nonzero.
  - ovf is sticky until reset or restart.
  - ovf is unaffected by entering S_ERR.
- Latency: one cycle. The character consumed at edge k is reflected in value/ok/err immediately after edge k.
- After an operator (S_OP): ok=0 and value holds the value as of the last digit.
- Leading zeros are legal ("007" = 7).
- restart together with in_valid=1: restart wins and the character is dropped.
- clr_n asserted mid-expression: immediate async clear, regardless of clk.

Test Plan:
1. W=16, clr_n pulse, then "3+4*5" one character per cycle with in_valid=1 -> value after each digit 3, 7, 23; final value=23, ok=1, err=0, ovf=0; ok=0 on the cycles after '+' and '*'.
2. "12*3+7" with in_valid toggled low for 2 cycles between '*' and '3' -> outputs frozen while in_valid=0; final value=43, ok=1.
3. "+5" after reset -> err=1, ok=0, value=0 after the first edge; the following '5' has no effect; restart=1 for one cycle -> err=0, value=0; then "5" -> value=5, ok=1.
4. "9*" then "x" (0x78) -> value=9, ok=0 after '*'; err=1, value=0 after 'x'; restart asserted together with in_valid=1 on the next edge -> reset state, character dropped.
5. W=8: "255*2" -> value=254, ovf=1, ok=1. Separately, "300" -> value=44, ovf=1. Then "1+1" after restart -> value=2, ovf=0.
6. Drive "8*8" and assert clr_n=0 asynchronously between clock edges after the second '8' -> value=0, ok=0, err=0, ovf=0 immediately; after release, "2+2" -> value=4.
